// File: rtl/sdf_stage_ctrl.sv
// Sequencer for one radix-2 single-path delay-feedback FFT stage: steers the
// half-frame delay FIFO and emits the aligned pair strobe, twiddle address and frame marker.
//
// state | meaning
// FILL  | first half of frame: samples written into the delay FIFO
// PAIR  | second half: FIFO head read out to meet the matching live sample
// DRAIN | frame abandoned: FIFO emptied, input ignored
module sdf_stage_ctrl #(
  parameter int half_len         = 512,
  parameter int cnt_len          = 9,
  parameter int bram_tf_addr_len = 9,
  parameter int tf_shift         = 0
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        data_in_valid,
  input  logic                        clear,
  input  logic                        fifo_full,
  input  logic                        fifo_empty,
  output logic                        fifo_wr_en,
  output logic                        fifo_rd_en,
  output logic                        pair_valid,
  output logic [bram_tf_addr_len-1:0] tf_addr,
  output logic                        frame_done,
  output logic                        err_underflow,
  output logic                        err_overflow
);

  typedef enum logic [1:0] {
    FILL  = 2'd0,
    PAIR  = 2'd1,
    DRAIN = 2'd2
  } state_t;

  localparam logic [cnt_len-1:0] CNT_LAST = cnt_len'(half_len - 1);

  state_t                      state;
  state_t                      state_nxt;
  logic [cnt_len-1:0]          cnt;
  logic [cnt_len-1:0]          cnt_nxt;
  logic                        last_sample;
  logic                        rd_pair;
  logic                        wr_ovf;
  logic                        rd_unf;
  logic [bram_tf_addr_len-1:0] tf_addr_nxt;

  assign last_sample = (cnt == CNT_LAST);
  // Shift after truncation gives the same low bits as shift-then-truncate.
  assign tf_addr_nxt = bram_tf_addr_len'(cnt) << tf_shift;

  always_comb begin
    state_nxt  = state;
    cnt_nxt    = cnt;
    fifo_wr_en = 1'b0;
    fifo_rd_en = 1'b0;
    rd_pair    = 1'b0;
    wr_ovf     = 1'b0;
    rd_unf     = 1'b0;
    case (state)
      FILL: begin
        fifo_wr_en = data_in_valid & ~fifo_full;
        wr_ovf     = data_in_valid & fifo_full;
        if (clear) begin
          state_nxt = DRAIN;
          cnt_nxt   = '0;
        end else if (data_in_valid) begin
          if (last_sample) begin
            cnt_nxt   = '0;
            state_nxt = PAIR;
          end else begin
            cnt_nxt = cnt + 1'b1;
          end
        end
      end
      PAIR: begin
        fifo_rd_en = data_in_valid & ~fifo_empty;
        rd_pair    = data_in_valid & ~fifo_empty;
        rd_unf     = data_in_valid & fifo_empty;
        if (clear) begin
          state_nxt = DRAIN;
          cnt_nxt   = '0;
        end else if (data_in_valid) begin
          if (last_sample) begin
            cnt_nxt   = '0;
            state_nxt = FILL;
          end else begin
            cnt_nxt = cnt + 1'b1;
          end
        end
      end
      DRAIN: begin
        fifo_rd_en = ~fifo_empty;
        cnt_nxt    = '0;
        if (fifo_empty) begin
          state_nxt = FILL;
        end
      end
      default: begin
        state_nxt = FILL;
        cnt_nxt   = '0;
      end
    endcase
    // The FIFO shares this reset; no strobes may leak out while it is held.
    if (rst) begin
      fifo_wr_en = 1'b0;
      fifo_rd_en = 1'b0;
      rd_pair    = 1'b0;
      wr_ovf     = 1'b0;
      rd_unf     = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= FILL;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  // Pair strobe and twiddle address lag the read by one cycle to meet FIFO dout.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pair_valid    <= 1'b0;
      tf_addr       <= '0;
      frame_done    <= 1'b0;
      err_underflow <= 1'b0;
      err_overflow  <= 1'b0;
    end else begin
      pair_valid    <= rd_pair;
      frame_done    <= rd_pair & last_sample;
      err_underflow <= err_underflow | rd_unf;
      err_overflow  <= err_overflow | wr_ovf;
      if (rd_pair) begin
        tf_addr <= tf_addr_nxt;
      end
    end
  end

endmodule

// File: tb/tb_sdf_stage_ctrl.sv
// Directed bench for sdf_stage_ctrl with half_len=4: two instances (tf_shift 0 and 1),
// a FIFO occupancy model driving the flags, and a pair scoreboard checked every cycle.
module tb_sdf_stage_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       data_in_valid;
  logic       clear;
  logic       fifo_full;
  logic       fifo_empty;
  logic       force_full;
  logic       force_empty;

  logic       wr0, rd0, pv0, fd0, eu0, eo0;
  logic [1:0] tf0;
  logic       wr1, rd1, pv1, fd1, eu1, eo1;
  logic [2:0] tf1;

  int vectors     = 0;
  int miscompares = 0;
  int cyc         = 0;
  int fcount      = 0;

  typedef struct {
    int idx;
    int cyc;
  } pair_t;
  pair_t sb[$];

  sdf_stage_ctrl #(
    .half_len(4), .cnt_len(2), .bram_tf_addr_len(2), .tf_shift(0)
  ) dut0 (
    .clk(clk), .rst(rst), .data_in_valid(data_in_valid), .clear(clear),
    .fifo_full(fifo_full), .fifo_empty(fifo_empty),
    .fifo_wr_en(wr0), .fifo_rd_en(rd0), .pair_valid(pv0), .tf_addr(tf0),
    .frame_done(fd0), .err_underflow(eu0), .err_overflow(eo0)
  );

  sdf_stage_ctrl #(
    .half_len(4), .cnt_len(2), .bram_tf_addr_len(3), .tf_shift(1)
  ) dut1 (
    .clk(clk), .rst(rst), .data_in_valid(data_in_valid), .clear(clear),
    .fifo_full(fifo_full), .fifo_empty(fifo_empty),
    .fifo_wr_en(wr1), .fifo_rd_en(rd1), .pair_valid(pv1), .tf_addr(tf1),
    .frame_done(fd1), .err_underflow(eu1), .err_overflow(eo1)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // 4-deep FIFO occupancy model, reset together with the controller.
  always @(posedge clk or posedge rst) begin
    if (rst) fcount <= 0;
    else     fcount <= fcount + (wr0 ? 1 : 0) - (rd0 ? 1 : 0);
  end

  assign fifo_full  = (fcount >= 4) || force_full;
  assign fifo_empty = (fcount == 0) || force_empty;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp)
    else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  // Every cycle out of reset: pair_valid must match the scoreboard head.
  always @(negedge clk) begin
    if (!rst) begin
      logic  exp_pv;
      pair_t e;
      exp_pv = (sb.size() > 0) && (sb[0].cyc == cyc);
      chk("pair_valid", {31'd0, pv0}, {31'd0, exp_pv});
      chk("pair_valid_s1", {31'd0, pv1}, {31'd0, exp_pv});
      if (exp_pv) begin
        e = sb.pop_front();
        chk("tf_addr", {30'd0, tf0}, e.idx);
        chk("tf_addr_s1", {29'd0, tf1}, (e.idx * 2) % 8);
        chk("frame_done", {31'd0, fd0}, (e.idx == 3) ? 1 : 0);
        chk("frame_done_s1", {31'd0, fd1}, (e.idx == 3) ? 1 : 0);
      end else begin
        chk("frame_done_idle", {31'd0, fd0}, 0);
        chk("frame_done_idle_s1", {31'd0, fd1}, 0);
      end
    end
  end

  // One clock cycle: drive at posedge+1, check enables at negedge, push any pair due next cycle.
  task automatic cycle(input logic v, input logic clr, input logic ewr, input logic erd,
                       input logic epair, input int idx);
    data_in_valid = v;
    clear         = clr;
    if (epair) sb.push_back('{idx: idx, cyc: cyc + 1});
    @(negedge clk);
    chk("wr_en", {31'd0, wr0}, {31'd0, ewr});
    chk("rd_en", {31'd0, rd0}, {31'd0, erd});
    chk("wr_en_s1", {31'd0, wr1}, {31'd0, ewr});
    chk("rd_en_s1", {31'd0, rd1}, {31'd0, erd});
    @(posedge clk);
    #1;
    data_in_valid = 1'b0;
    clear         = 1'b0;
  endtask

  task automatic frames(input int n);
    for (int f = 0; f < n; f++) begin
      for (int i = 0; i < 4; i++) cycle(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 0);
      for (int i = 0; i < 4; i++) cycle(1'b1, 1'b0, 1'b0, 1'b1, 1'b1, i);
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 0);
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_wr"}, {30'd0, wr1, wr0}, 0);
    chk({tag, "_rd"}, {30'd0, rd1, rd0}, 0);
    chk({tag, "_pv"}, {30'd0, pv1, pv0}, 0);
    chk({tag, "_tf"}, {27'd0, tf1, tf0}, 0);
    chk({tag, "_fd"}, {30'd0, fd1, fd0}, 0);
    chk({tag, "_eu"}, {30'd0, eu1, eu0}, 0);
    chk({tag, "_eo"}, {30'd0, eo1, eo0}, 0);
  endtask

  task automatic chk_err(input string tag, input logic exp_unf, input logic exp_ovf);
    chk({tag, "_unf"}, {30'd0, eu1, eu0}, {30'd0, exp_unf, exp_unf});
    chk({tag, "_ovf"}, {30'd0, eo1, eo0}, {30'd0, exp_ovf, exp_ovf});
  endtask

  initial begin
    rst           = 1'b1;
    data_in_valid = 1'b1;
    clear         = 1'b0;
    force_full    = 1'b0;
    force_empty   = 1'b0;
    #3;
    chk_zero("reset");
    data_in_valid = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b0;

    // Single frame, back-to-back samples.
    frames(1);
    idle(2);
    chk_err("t1", 1'b0, 1'b0);

    // Same frame with a gap after every sample.
    for (int i = 0; i < 4; i++) begin
      cycle(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 0);
      idle(1);
    end
    for (int i = 0; i < 4; i++) begin
      cycle(1'b1, 1'b0, 1'b0, 1'b1, 1'b1, i);
      idle(1);
    end
    idle(1);

    // Two frames with no idle cycle between them.
    frames(2);
    idle(2);
    chk("fifo_level_t3", fcount, 0);

    // Clear after three FILL samples: three drain reads, valid ignored, then a clean frame.
    for (int i = 0; i < 3; i++) cycle(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 0);
    cycle(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 0);
    cycle(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 0);
    cycle(1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 0);
    cycle(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 0);
    cycle(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 0);
    chk("fifo_level_drained", fcount, 0);
    frames(1);
    idle(2);
    chk_err("t5", 1'b0, 1'b0);

    // FIFO reported empty on the third PAIR sample: no read, no pair, frame still ends.
    for (int i = 0; i < 4; i++) cycle(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 0);
    cycle(1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 0);
    cycle(1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1);
    force_empty = 1'b1;
    cycle(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 0);
    force_empty = 1'b0;
    cycle(1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 3);
    idle(1);
    chk_err("t4", 1'b1, 1'b0);

    // One entry left over, so the fourth FILL sample meets a full FIFO.
    for (int i = 0; i < 3; i++) cycle(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 0);
    cycle(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 0);
    chk_err("ovf", 1'b1, 1'b1);
    cycle(1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 0);
    cycle(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 0);

    // Asynchronous reset in the middle of a PAIR cycle.
    data_in_valid = 1'b1;
    #1;
    chk("rd_en_pre_rst", {31'd0, rd0}, 1);
    chk("pv_pre_rst", {31'd0, pv0}, 1);
    chk("tf_addr_pre_rst", {30'd0, tf0}, 1);
    chk("tf_addr_s1_pre_rst", {29'd0, tf1}, 2);
    rst = 1'b1;
    #1;
    chk_zero("async_rst");
    @(posedge clk);
    #1;
    chk_zero("rst_held");
    rst           = 1'b0;
    data_in_valid = 1'b0;
    frames(1);
    idle(2);
    chk_err("after_rst", 1'b0, 1'b0);
    chk("scoreboard_empty", sb.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
